gun_mag: RTL and testbench
==========================

Name: gun_mag

Overview:
- Parametrised next-generation gun controller.
- Converts mouse-bin coordinates to a screen shot position and fires on the left mouse button.
- Adds a finite magazine, timed reload (manual on right button, automatic when empty), an ammo count output and configurable cooldown/reload durations.
- Sits between the PS/2 mouse driver and the hit-detection / HUD logic. Crosshair rendering stays in crosshair_render at top level.

Parameters:
- BIN_W, 6, width of bin_x/bin_y.
- BIN_SIZE, 10, pixels per mouse bin.
- CROSSHAIR_RADIUS, 32, offset from bin top-left to crosshair centre.
- MAX_H, 480, screen height; y-axis is inverted.
- CD_TICKS, 10_000_000, cycles spent in cooldown after each shot (>=1).
- RELOAD_TICKS, 50_000_000, cycles spent reloading (>=1).
- MAG_SIZE, 8, rounds per magazine (>=1).

Ports:
- clk  in  1  50MHz clock.
- reset  in  1  synchronous, active-high reset.
- bin_x  in  BIN_W  mouse x bin index.
- bin_y  in  BIN_W  mouse y bin index.
- button_left  in  1  trigger, level from mouse driver.
- button_right  in  1  manual reload request, level.
- fire_mode  in  1  0 = semi-auto, 1 = full-auto (effective only with AUTO_FIRE_EN).
- shoot_x  out  10  latched x of last shot.
- shoot_y  out  9  latched y of last shot.
- shot  out  1  one-cycle pulse per fired round.
- ammo  out  $clog2(MAG_SIZE+1)  rounds remaining.
- cd  out  1  high while in S_CD.
- reloading  out  1  high while in S_RELOAD.

Behaviour:
- Position (combinational, internal):
  - aim_x = 10'(bin_x*BIN_SIZE) + CROSSHAIR_RADIUS.
  - aim_y = 9'(MAX_H) - 9'(bin_y*BIN_SIZE) + CROSSHAIR_RADIUS.
  - All arithmetic truncates/wraps to 10/9 bits. No saturation.
- Trigger:
  - trig_edge = button_left & ~button_left_q, where button_left_q is a registered copy.
  - Semi mode uses trig_edge; auto mode uses button_left level.
- States: S_IDLE, S_CD, S_RELOAD. All three reset to S_IDLE.
- S_IDLE:
  - Fire accept when trigger is active and ammo>0. On the next edge: shot<=1, shoot_x/y<=aim_x/aim_y, ammo<=ammo-1, go to S_CD.
  - Else, if button_right and ammo<MAG_SIZE, go to S_RELOAD.
  - If trigger and button_right arrive together with ammo>0, fire wins.
  - Trigger with ammo==0 is ignored (no shot).
- S_CD:
  - Lasts exactly CD_TICKS cycles; the shot pulse coincides with the first S_CD cycle.
  - On exit: if ammo==0, go to S_RELOAD (auto-reload); else go to S_IDLE.
  - Triggers and button_right in S_CD are ignored and not queued.
- S_RELOAD:
  - Lasts exactly RELOAD_TICKS cycles.
  - On the final cycle's edge: ammo<=MAG_SIZE, go to S_IDLE.
  - Inputs are ignored during reload.
- Latency: trigger sampled in cycle N gives shot=1 in cycle N+1. The next accepted shot is no earlier than cycle N+1+CD_TICKS.
- A single tick counter (width $clog2(max(CD_TICKS,RELOAD_TICKS))+1) clears on every state entry.
- shot is registered and high for one cycle only.
- cd = (ps==S_CD); reloading = (ps==S_RELOAD).
- Reset values: ps=S_IDLE, ammo=MAG_SIZE, shot=0, shoot_x=0, shoot_y=0, counter=0, button_left_q=0.
- Reset mid-cooldown or mid-reload aborts immediately. ammo returns to MAG_SIZE and no shot pulse is emitted.
- Semi mode: a button held through cooldown does not refire; a new press is required.
- Auto mode: a held button refires every CD_TICKS+1 cycles until the magazine is empty, then auto-reloads.

Optional Feature:
- Macro: GUN_MAG_AUTO_FIRE_EN.
- Defined: fire_mode selects semi/auto as above.
- Undefined: fire_mode is ignored, behaviour is always semi-auto, and the auto-mode path is not synthesised.

Test Plan (CD_TICKS=4, RELOAD_TICKS=8, MAG_SIZE=3):
- Reset, then bin_x=6, bin_y=9, button_left press -> shot=1 one cycle later; shoot_x=92, shoot_y=422; ammo=2; cd=1 for exactly 4 cycles.
- Press held through cooldown in semi mode -> no second shot; release then press -> second shot; ammo=1.
- Three shots to empty -> after the third cooldown reloading=1 for 8 cycles; then ammo=3, ps=S_IDLE; a trigger while reloading -> no shot.
- ammo=2 with button_right in IDLE -> reload for 8 cycles, ammo=3. button_right with ammo=3 -> stays IDLE.
- AUTO_FIRE_EN, fire_mode=1, button held -> shots at cycles N+1, N+6, N+11, then 8-cycle reload, then firing resumes.
- Reset asserted in the 2nd reload cycle -> next cycle: ps=S_IDLE, ammo=3, shot=0, reloading=0.

Source files
------------

// File: rtl/gun_mag_if.sv
// Mouse-side inputs and shot/HUD outputs of the gun_mag controller.
// master drives the mouse inputs; slave is the gun_mag controller.
interface gun_mag_if #(
    parameter int BIN_W    = 6,
    parameter int MAG_SIZE = 8
);
    localparam int AMMO_W = $clog2(MAG_SIZE + 1);

    logic [BIN_W-1:0]  bin_x;
    logic [BIN_W-1:0]  bin_y;
    logic              button_left;
    logic              button_right;
    logic              fire_mode;
    logic [9:0]        shoot_x;
    logic [8:0]        shoot_y;
    logic              shot;
    logic [AMMO_W-1:0] ammo;
    logic              cd;
    logic              reloading;

    modport master (
        output bin_x, bin_y, button_left, button_right, fire_mode,
        input  shoot_x, shoot_y, shot, ammo, cd, reloading
    );

    modport slave (
        input  bin_x, bin_y, button_left, button_right, fire_mode,
        output shoot_x, shoot_y, shot, ammo, cd, reloading
    );
endinterface

// File: rtl/gun_mag.sv
// Gun controller with finite magazine, cooldown and timed reload.
// Define GUN_MAG_AUTO_FIRE_EN to let fire_mode select full-auto on a held trigger.
module gun_mag #(
    parameter int BIN_W            = 6,
    parameter int BIN_SIZE         = 10,
    parameter int CROSSHAIR_RADIUS = 32,
    parameter int MAX_H            = 480,
    parameter int CD_TICKS         = 10_000_000,
    parameter int RELOAD_TICKS     = 50_000_000,
    parameter int MAG_SIZE         = 8
) (
    input  logic      clk,
    input  logic      reset,
    gun_mag_if.slave  bus
);
    localparam int AMMO_W  = $clog2(MAG_SIZE + 1);
    localparam int MAX_T   = (CD_TICKS > RELOAD_TICKS) ? CD_TICKS : RELOAD_TICKS;
    localparam int CNT_W   = $clog2(MAX_T) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CD,
        S_RELOAD
    } state_t;

    state_t            r_ps;
    state_t            w_ns;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_btn_q;
    logic [AMMO_W-1:0] r_ammo;
    logic              r_shot;
    logic [9:0]        r_shoot_x;
    logic [8:0]        r_shoot_y;

    logic [9:0]        w_aim_x;
    logic [8:0]        w_aim_y;
    logic              w_trig_edge;
    logic              w_trig;
    logic              w_fire;
    logic              w_cd_done;
    logic              w_rl_done;

    // Screen y grows downwards while mouse bins grow upwards; everything wraps.
    assign w_aim_x = 10'(10'(bus.bin_x * BIN_SIZE) + 10'(CROSSHAIR_RADIUS));
    assign w_aim_y = 9'(9'(MAX_H) - 9'(bus.bin_y * BIN_SIZE) + 9'(CROSSHAIR_RADIUS));

    assign w_trig_edge = bus.button_left & ~r_btn_q;

`ifdef GUN_MAG_AUTO_FIRE_EN
    assign w_trig = bus.fire_mode ? bus.button_left : w_trig_edge;
`else
    logic w_unused_fire_mode;
    assign w_unused_fire_mode = bus.fire_mode;
    assign w_trig = w_trig_edge;
`endif

    assign w_cd_done = (r_cnt == CNT_W'(CD_TICKS - 1));
    assign w_rl_done = (r_cnt == CNT_W'(RELOAD_TICKS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ps <= S_IDLE;
        end else begin
            r_ps <= w_ns;
        end
    end

    always_comb begin
        w_ns   = r_ps;
        w_fire = 1'b0;
        case (r_ps)
            S_IDLE: begin
                if (w_trig && (r_ammo != '0)) begin
                    w_fire = 1'b1;
                    w_ns   = S_CD;
                end else if (bus.button_right && (r_ammo < AMMO_W'(MAG_SIZE))) begin
                    w_ns = S_RELOAD;
                end
            end
            S_CD: begin
                if (w_cd_done) begin
                    w_ns = (r_ammo == '0) ? S_RELOAD : S_IDLE;
                end
            end
            S_RELOAD: begin
                if (w_rl_done) begin
                    w_ns = S_IDLE;
                end
            end
            default: w_ns = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_btn_q   <= 1'b0;
            r_ammo    <= AMMO_W'(MAG_SIZE);
            r_shot    <= 1'b0;
            r_shoot_x <= '0;
            r_shoot_y <= '0;
        end else begin
            r_btn_q <= bus.button_left;
            r_shot  <= w_fire;

            // Counter restarts on each state entry and idles at zero.
            if ((w_ns != r_ps) || (r_ps == S_IDLE)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_fire) begin
                r_shoot_x <= w_aim_x;
                r_shoot_y <= w_aim_y;
                r_ammo    <= r_ammo - AMMO_W'(1);
            end else if ((r_ps == S_RELOAD) && w_rl_done) begin
                r_ammo <= AMMO_W'(MAG_SIZE);
            end
        end
    end

    assign bus.shoot_x   = r_shoot_x;
    assign bus.shoot_y   = r_shoot_y;
    assign bus.shot      = r_shot;
    assign bus.ammo      = r_ammo;
    assign bus.cd        = (r_ps == S_CD);
    assign bus.reloading = (r_ps == S_RELOAD);
endmodule

// File: tb/tb_gun_mag.sv
// Scoreboard bench for gun_mag: timestamp-style reference model plus decoupled monitor.
module tb_gun_mag;
    localparam int CD   = 4;
    localparam int RL   = 8;
    localparam int MAG  = 3;
`ifdef GUN_MAG_AUTO_FIRE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gun_mag_if #(.BIN_W(6), .MAG_SIZE(MAG)) bus ();

    gun_mag #(
        .BIN_W(6), .BIN_SIZE(10), .CROSSHAIR_RADIUS(32), .MAX_H(480),
        .CD_TICKS(CD), .RELOAD_TICKS(RL), .MAG_SIZE(MAG)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    typedef struct { int x; int y; } shot_t;
    shot_t sb[$];

    // Reference model: ammo plus "cycles of cooldown/reload still to go".
    int m_ammo = MAG;
    int m_cd_left = 0;
    int m_rl_left = 0;
    bit m_prev = 1'b0;
    bit m_shot = 1'b0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        bit trig;
        shot_t s;
        if (reset) begin
            m_ammo = MAG; m_cd_left = 0; m_rl_left = 0; m_prev = 1'b0; m_shot = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_shot = 1'b0;
            trig = (AUTO && bus.fire_mode) ? bus.button_left : (bus.button_left && !m_prev);
            m_prev = bus.button_left;
            if (m_cd_left > 0) begin
                m_cd_left--;
                if (m_cd_left == 0 && m_ammo == 0) m_rl_left = RL;
            end else if (m_rl_left > 0) begin
                m_rl_left--;
                if (m_rl_left == 0) m_ammo = MAG;
            end else if (trig && m_ammo > 0) begin
                m_ammo--;
                m_cd_left = CD;
                m_shot = 1'b1;
                s.x = (int'(bus.bin_x) * 10 + 32) % 1024;
                s.y = (((480 - int'(bus.bin_y) * 10 + 32) % 512) + 512) % 512;
                sb.push_back(s);
            end else if (bus.button_right && m_ammo < MAG) begin
                m_rl_left = RL;
            end
        end
    end

    always @(negedge clk) begin
        shot_t e;
        if (m_valid) begin
            chk("shot", int'(bus.shot), int'(m_shot));
            chk("cd", int'(bus.cd), int'(m_cd_left > 0));
            chk("reloading", int'(bus.reloading), int'(m_rl_left > 0));
            chk("ammo", int'(bus.ammo), m_ammo);
            if (bus.shot === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_shot", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("shoot_x", int'(bus.shoot_x), e.x);
                    chk("shoot_y", int'(bus.shoot_y), e.y);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input int hold, input int gap);
        bus.button_left = 1'b1;
        step(hold);
        bus.button_left = 1'b0;
        step(gap);
    endtask

    initial begin
        int hold;
        bit seen;
        bus.bin_x = 6'd0; bus.bin_y = 6'd0;
        bus.button_left = 1'b0; bus.button_right = 1'b0; bus.fire_mode = 1'b0;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(1);
        chk("reset_ammo", int'(bus.ammo), MAG);
        chk("reset_shoot_x", int'(bus.shoot_x), 0);

        // First shot, held through cooldown (semi mode must not refire).
        bus.bin_x = 6'd6; bus.bin_y = 6'd9;
        bus.button_left = 1'b1;
        @(posedge clk); #1;
        chk("first_shot", int'(bus.shot), 1);
        chk("first_x", int'(bus.shoot_x), 92);
        chk("first_y", int'(bus.shoot_y), 422);
        chk("first_ammo", int'(bus.ammo), 2);
        #1;
        step(9);
        bus.button_left = 1'b0;
        step(1);
        press(1, 6);
        chk("second_ammo", int'(bus.ammo), 1);
        bus.bin_x = 6'd63; bus.bin_y = 6'd63;
        press(1, 1);

        // Wait for the automatic reload, then reset in its 2nd cycle.
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.reloading === 1'b1) seen = 1'b1;
            else step(1);
        end
        chk("auto_reload_seen", int'(seen), 1);
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst_reloading", int'(bus.reloading), 0);
        chk("rst_ammo", int'(bus.ammo), MAG);
        chk("rst_shot", int'(bus.shot), 0);
        step(2);

        // Manual reload with partial magazine, and with a full one.
        press(1, 6);
        bus.button_right = 1'b1;
        step(1);
        bus.button_right = 1'b0;
        step(RL + 2);
        bus.button_right = 1'b1;
        step(2);
        bus.button_right = 1'b0;

        // Held trigger in full-auto (plain semi behaviour in the default build).
        bus.fire_mode = 1'b1;
        press(30, 12);
        bus.fire_mode = 1'b0;

        hold = 1;
        for (int c = 0; c < 3000; c++) begin
            hold--;
            if (hold <= 0) begin
                bus.button_left = ~bus.button_left;
                hold = $urandom_range(1, 9);
            end
            if ($urandom_range(0, 5) == 0) begin
                bus.bin_x = 6'($urandom_range(0, 63));
                bus.bin_y = 6'($urandom_range(0, 63));
            end
            bus.button_right = ($urandom_range(0, 11) == 0);
            reset = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 99) == 0) bus.fire_mode = ~bus.fire_mode;
            step(1);
        end
        reset = 1'b0;
        bus.button_left = 1'b0;
        bus.button_right = 1'b0;
        step(RL + CD + 4);
        chk("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
